// File: rtl/cell_test_sequencer.sv
// cell_test_sequencer
//   Applies every input pattern to a bank of cells under test, waits for the
//   responses to settle, then compares each channel's synchronized response
//   with its expected truth table. Mismatches set sticky per-channel flags
//   and add to a saturating error counter; completed passes are counted too.
//
// Ports
//   wb_clk_i    sole clock, rising edge
//   wb_rst_ni   asynchronous active-low reset
//   start_i     start request, only honoured in IDLE
//   abort_i     stop request, returns to IDLE on the next edge
//   loop_i      1 = run passes back to back, 0 = single pass
//   exp_tt_i    expected truth tables, bit [ch*2**IN_W + p]
//   resp_i      asynchronous cell responses
//   stim_o      pattern broadcast to all cells
//   busy_o      high whenever the FSM is not IDLE
//   done_o      one-cycle pulse at the end of a completed run
//   fail_o      sticky per-channel mismatch flags
//   err_cnt_o   saturating total mismatch count
//   pass_cnt_o  saturating completed-pass count
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; stim_o held at 0
// APPLY   | stim_o = pattern, settle down-counter running
// SAMPLE  | one cycle: compare responses, advance pattern
// DONE    | one cycle: done_o pulse, then back to IDLE

module cell_test_sequencer #(
    parameter int CHANNELS = 8,
    parameter int IN_W     = 3,
    parameter int SETTLE   = 4,
    parameter int CNT_W    = 16
) (
    input  logic                            wb_clk_i,
    input  logic                            wb_rst_ni,
    input  logic                            start_i,
    input  logic                            abort_i,
    input  logic                            loop_i,
    input  logic [CHANNELS*(2**IN_W)-1:0]   exp_tt_i,
    input  logic [CHANNELS-1:0]             resp_i,
    output logic [IN_W-1:0]                 stim_o,
    output logic                            busy_o,
    output logic                            done_o,
    output logic [CHANNELS-1:0]             fail_o,
    output logic [CNT_W-1:0]                err_cnt_o,
    output logic [CNT_W-1:0]                pass_cnt_o
);

    localparam int NPAT = 2**IN_W;
    localparam int SW   = $clog2(SETTLE);

    // APPLY lasts SETTLE cycles: load SETTLE-1 and leave when the counter hits 0.
    localparam logic [SW-1:0]    SETTLE_LD = SW'(SETTLE - 1);
    localparam logic [IN_W-1:0]  PAT_LAST  = IN_W'(NPAT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [IN_W-1:0]     pat_q, pat_d;
    logic [SW-1:0]       settle_q, settle_d;
    logic [CHANNELS-1:0] fail_q, fail_d;
    logic [CNT_W-1:0]    err_q, err_d;
    logic [CNT_W-1:0]    pass_q, pass_d;
    logic [CHANNELS-1:0] resp_s1_q, resp_s2_q;
    logic [CHANNELS-1:0] exp_bits;
    logic [CHANNELS-1:0] mis;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            resp_s1_q <= '0;
            resp_s2_q <= '0;
        end else begin
            resp_s1_q <= resp_i;
            resp_s2_q <= resp_s1_q;
        end
    end

    // Expected bit of every channel for the current pattern.
    always_comb begin
        logic [NPAT-1:0] row;
        row      = '0;
        exp_bits = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            row          = exp_tt_i[ch*NPAT +: NPAT];
            exp_bits[ch] = row[pat_q];
        end
    end

    assign mis = resp_s2_q ^ exp_bits;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q  <= ST_IDLE;
            pat_q    <= '0;
            settle_q <= '0;
            fail_q   <= '0;
            err_q    <= '0;
            pass_q   <= '0;
        end else begin
            state_q  <= state_d;
            pat_q    <= pat_d;
            settle_q <= settle_d;
            fail_q   <= fail_d;
            err_q    <= err_d;
            pass_q   <= pass_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        settle_d = settle_q;
        fail_d   = fail_q;
        err_d    = err_q;
        pass_d   = pass_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i && !abort_i) begin
                    fail_d   = '0;
                    err_d    = '0;
                    pass_d   = '0;
                    pat_d    = '0;
                    settle_d = SETTLE_LD;
                    state_d  = ST_APPLY;
                end
            end

            ST_APPLY: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (settle_q == '0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    settle_d = settle_q - SW'(1);
                end
            end

            ST_SAMPLE: begin
                // The sample is recorded even when abort arrives in this cycle.
                fail_d = fail_q | mis;
                // Saturating popcount add, one channel at a time.
                for (int ch = 0; ch < CHANNELS; ch++) begin
                    if (mis[ch] && (err_d != CNT_MAX)) begin
                        err_d = err_d + CNT_W'(1);
                    end
                end
                settle_d = SETTLE_LD;
                if (pat_q == PAT_LAST) begin
                    pat_d = '0;
                    if (pass_q != CNT_MAX) begin
                        pass_d = pass_q + CNT_W'(1);
                    end
                    state_d = loop_i ? ST_APPLY : ST_DONE;
                end else begin
                    pat_d   = pat_q + IN_W'(1);
                    state_d = ST_APPLY;
                end
                if (abort_i) begin
                    state_d = ST_IDLE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign stim_o     = (state_q == ST_IDLE) ? '0 : pat_q;
    assign busy_o     = (state_q != ST_IDLE);
    assign done_o     = (state_q == ST_DONE);
    assign fail_o     = fail_q;
    assign err_cnt_o  = err_q;
    assign pass_cnt_o = pass_q;

endmodule

// File: tb/tb_cell_test_sequencer.sv
module tb_cell_test_sequencer;

    localparam int CH = 4;
    localparam int IW = 2;
    localparam int ST = 3;
    localparam int CW = 8;

    logic            clk;
    logic            rst_n;
    logic            start, abort, loop_en;
    logic [15:0]     exp_tt;
    logic [CH-1:0]   resp;
    logic [IW-1:0]   stim;
    logic            busy, done;
    logic [CH-1:0]   fail;
    logic [CW-1:0]   err_cnt, pass_cnt;

    logic            start_s, abort_s, loop_s;
    logic [IW-1:0]   stim_s;
    logic            busy_s, done_s;
    logic [CH-1:0]   fail_s;
    logic [3:0]      err_s, pass_s;

    // 0 = ideal cells, 1 = channel 2 stuck at 1, 2 = every channel inverted
    logic [1:0]      mode;
    logic            use_sat;
    int              n_tot, n_bad, done_cnt, d0;

    cell_test_sequencer #(.CHANNELS(CH), .IN_W(IW), .SETTLE(ST), .CNT_W(CW)) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .start_i    (start),
        .abort_i    (abort),
        .loop_i     (loop_en),
        .exp_tt_i   (exp_tt),
        .resp_i     (resp),
        .stim_o     (stim),
        .busy_o     (busy),
        .done_o     (done),
        .fail_o     (fail),
        .err_cnt_o  (err_cnt),
        .pass_cnt_o (pass_cnt)
    );

    cell_test_sequencer #(.CHANNELS(CH), .IN_W(IW), .SETTLE(ST), .CNT_W(4)) dut_sat (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .start_i    (start_s),
        .abort_i    (abort_s),
        .loop_i     (loop_s),
        .exp_tt_i   (exp_tt),
        .resp_i     (resp),
        .stim_o     (stim_s),
        .busy_o     (busy_s),
        .done_o     (done_s),
        .fail_o     (fail_s),
        .err_cnt_o  (err_s),
        .pass_cnt_o (pass_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        logic [3:0]    row;
        logic          ideal;
        logic [IW-1:0] st_sel;
        st_sel = use_sat ? stim_s : stim;
        row    = '0;
        ideal  = 1'b0;
        resp   = '0;
        for (int ch = 0; ch < CH; ch++) begin
            row   = exp_tt[ch*4 +: 4];
            ideal = row[st_sel];
            case (mode)
                2'd0:    resp[ch] = ideal;
                2'd1:    resp[ch] = (ch == 2) ? 1'b1 : ideal;
                default: resp[ch] = ~ideal;
            endcase
        end
    end

    always @(negedge clk) if (done) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tot++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        n_tot = 0; n_bad = 0; done_cnt = 0;
        rst_n = 1'b0;
        start = 1'b0; abort = 1'b0; loop_en = 1'b0;
        start_s = 1'b0; abort_s = 1'b0; loop_s = 1'b0;
        exp_tt = 16'h8E68; mode = 2'd0; use_sat = 1'b0;

        #12;
        chk("rst_stim",  32'(stim), 0);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_done",  32'(done), 0);
        chk("rst_fail",  32'(fail), 0);
        chk("rst_err",   32'(err_cnt), 0);
        chk("rst_pass",  32'(pass_cnt), 0);
        chk("rst_err_s", 32'(err_s), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // matching pass with ideal cells
        d0 = done_cnt;
        start = 1'b1; tick(); start = 1'b0;
        chk("t1_busy", 32'(busy), 1);
        repeat (15) tick();
        chk("t1_stim_last", 32'(stim), 3);
        chk("t1_done_early", 32'(done), 0);
        tick();
        chk("t1_done", 32'(done), 1);
        chk("t1_pass", 32'(pass_cnt), 1);
        tick();
        chk("t1_done_clr", 32'(done), 0);
        chk("t1_idle", 32'(busy), 0);
        chk("t1_fail", 32'(fail), 0);
        chk("t1_err", 32'(err_cnt), 0);
        chk("t1_done_n", 32'(done_cnt - d0), 1);

        // channel 2 stuck at 1 against truth table 4'h8
        exp_tt = 16'h8868; mode = 2'd1;
        start = 1'b1; tick(); start = 1'b0;
        repeat (16) tick();
        chk("t2_done", 32'(done), 1);
        chk("t2_fail", 32'(fail), 32'h4);
        chk("t2_err", 32'(err_cnt), 3);
        chk("t2_pass", 32'(pass_cnt), 1);
        tick();

        // loop three passes with every channel wrong, then abort
        mode = 2'd2; loop_en = 1'b1;
        d0 = done_cnt;
        start = 1'b1; tick(); start = 1'b0;
        repeat (47) tick();
        chk("t3_err_e47", 32'(err_cnt), 44);
        chk("t3_pass_e47", 32'(pass_cnt), 2);
        tick();
        chk("t3_err_e48", 32'(err_cnt), 48);
        chk("t3_pass_e48", 32'(pass_cnt), 3);
        chk("t3_busy", 32'(busy), 1);
        abort = 1'b1; tick(); abort = 1'b0;
        loop_en = 1'b0;
        chk("t3_abort_busy", 32'(busy), 0);
        chk("t3_pass", 32'(pass_cnt), 3);
        chk("t3_err", 32'(err_cnt), 48);
        chk("t3_fail", 32'(fail), 32'hF);
        chk("t3_no_done", 32'(done_cnt - d0), 0);

        // start together with abort in IDLE
        start = 1'b1; abort = 1'b1; tick();
        start = 1'b0; abort = 1'b0;
        chk("t4_contend_busy", 32'(busy), 0);
        chk("t4_contend_err", 32'(err_cnt), 48);

        // start while busy must not clear counters
        start = 1'b1; tick(); start = 1'b0;
        repeat (5) tick();
        chk("t4_err_mid", 32'(err_cnt), 4);
        start = 1'b1; tick(); start = 1'b0;
        chk("t4_err_hold", 32'(err_cnt), 4);
        chk("t4_busy_hold", 32'(busy), 1);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (done) seen = 1'b1;
        end
        chk("t4_done_wait", 32'(seen), 1);
        chk("t4_err_end", 32'(err_cnt), 16);
        chk("t4_pass_end", 32'(pass_cnt), 1);
        tick();

        // abort coinciding with SAMPLE still records the sample
        start = 1'b1; tick(); start = 1'b0;
        repeat (3) tick();
        abort = 1'b1; tick(); abort = 1'b0;
        chk("t5_abort_busy", 32'(busy), 0);
        chk("t5_abort_err", 32'(err_cnt), 4);
        chk("t5_abort_fail", 32'(fail), 32'hF);

        // reset during APPLY of pattern 2
        start = 1'b1; tick(); start = 1'b0;
        repeat (9) tick();
        chk("t6_stim_p2", 32'(stim), 2);
        chk("t6_err_pre", 32'(err_cnt), 8);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_stim", 32'(stim), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_fail", 32'(fail), 0);
        chk("t6_rst_err", 32'(err_cnt), 0);
        chk("t6_rst_pass", 32'(pass_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        mode = 2'd0; exp_tt = 16'h8E68;
        d0 = done_cnt;
        start = 1'b1; tick(); start = 1'b0;
        repeat (16) tick();
        chk("t6_rerun_done", 32'(done), 1);
        chk("t6_rerun_err", 32'(err_cnt), 0);
        chk("t6_rerun_pass", 32'(pass_cnt), 1);
        tick();
        chk("t6_done_n", 32'(done_cnt - d0), 1);

        // saturation on a 4-bit counter
        use_sat = 1'b1; mode = 2'd2; loop_s = 1'b1;
        start_s = 1'b1; tick(); start_s = 1'b0;
        repeat (16) tick();
        chk("t7_err_p1", 32'(err_s), 15);
        chk("t7_pass_p1", 32'(pass_s), 1);
        repeat (16) tick();
        chk("t7_err_p2", 32'(err_s), 15);
        chk("t7_pass_p2", 32'(pass_s), 2);
        chk("t7_fail", 32'(fail_s), 32'hF);
        abort_s = 1'b1; tick(); abort_s = 1'b0;
        chk("t7_abort_busy", 32'(busy_s), 0);
        chk("t7_no_done", 32'(done_s), 0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
